uart_tx_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one uart_tx transmitter among N_REQ byte producers.
- Picks a requester, issues a one-cycle start with the latched byte, then waits for the transmitter's end-of-frame indication.
- Enforces an inter-frame gap, and recovers with an error pulse if the transmitter never signals completion.
- Sits between the producers (command/status/debug sources) and the single uart_tx instance.

---
 rtl/uart_tx_arb_if.sv | 42 ++++
 rtl/uart_tx_arb.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and uart_tx handshake bundle for uart_tx_arb
//
// Purpose: groups the producer-side request/accept signals and the uart_tx-side
// start/data/completion signals, plus arbiter status, into one bundle.
// Ports (signals):
//   req_valid   [N_REQ]    producer byte available (held until req_ready)
//   req_data    [8*N_REQ]  producer bytes, requester i at [8i+7:8i]
//   req_ready   [N_REQ]    one-hot acceptance pulse
//   tx_start    [1]        start pulse to uart_tx
//   tx_data     [8]        byte to uart_tx
//   tx_busy     [1]        uart_tx end-of-frame indication
//   grant_id    [clog2]    current or last granted requester
//   active      [1]        arbiter is in ISSUE, WAIT or GAP
//   frame_done  [1]        frame completed pulse
//   timeout_err [1]        frame abandoned pulse
// Modports: slave = arbiter side, master = producers/transmitter/observer side.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
) ();
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [IDW-1:0]     grant_id;
  logic               active;
  logic               frame_done;
  logic               timeout_err;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, frame_done, timeout_err
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, frame_done, timeout_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx among N_REQ producers
//
// Purpose: picks a requester round-robin, issues a one-cycle start with the
// latched byte, waits for the transmitter's end-of-frame, forces an idle gap,
// and abandons the frame with an error pulse if completion never arrives.
// Ports:
//   clk_t  in  clock
//   srst   in  synchronous active-high reset
//   bus    uart_tx_arb_if.slave  (req_valid/req_data/req_ready, tx_start/tx_data/
//          tx_busy, grant_id, active, frame_done, timeout_err); all outputs registered
module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic          clk_t,
  input  logic          srst,
  uart_tx_arb_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             active_q, active_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             any_req;
  logic [IDW-1:0]   win_id;
  logic [7:0]       win_data;
  logic             wait_expired;
  int               cand;

  // Round-robin search starting just after the last winner.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!any_req && bus.req_valid[IDW'(cand)]) begin
        any_req = 1'b1;
        win_id  = IDW'(cand);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == IDW'(i)) win_data = bus.req_data[8*i +: 8];
    end
  end

  // cnt_q is 0 in the first WAIT cycle; firing at TIMEOUT-2 makes WAIT last
  // TIMEOUT-1 cycles so timeout_err lands TIMEOUT cycles after tx_start.
  assign wait_expired = (cnt_q == TW'(TIMEOUT - 2));

  // State register (holds all registered outputs and counters too).
  always_ff @(posedge clk_t) begin
    if (srst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_q       <= '0;
      last_q        <= IDW'(N_REQ - 1);
      active_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      active_q      <= active_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.tx_busy || wait_expired) state_d = S_GAP;
      S_GAP:   if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take at the edge,
  // so each pulse is visible in the cycle of the state it belongs to.
  always_comb begin
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    tx_data_d     = tx_data_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    active_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          tx_data_d   = win_data;
          grant_d     = win_id;
          last_d      = win_id;
          req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
          tx_start_d  = 1'b1;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // Completion takes precedence over a coincident timeout.
        if (bus.tx_busy) begin
          frame_done_d = 1'b1;
          gap_d        = '0;
        end else if (wait_expired) begin
          timeout_err_d = 1'b1;
          gap_d         = '0;
        end
      end
      S_GAP:   gap_d = gap_q + GW'(1);
      default: ;
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 32;

  logic clk_t = 1'b0;
  logic srst  = 1'b1;

  uart_tx_arb_if #(.N_REQ(N)) bus ();

  uart_tx_arb #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_t (clk_t),
    .srst  (srst),
    .bus   (bus)
  );

  always #5 clk_t = ~clk_t;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int last_m    = N - 1;

  // Observations of one frame, cycle offsets relative to the tx_start cycle.
  int         r_lat, r_gid, r_fd_at, r_fd_cnt, r_to_at, r_to_cnt, r_idle_at;
  logic [7:0] r_dat;
  logic [N-1:0] r_rdy;

  // Round-robin reference: first valid requester after the last grant.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_m + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // Runs one frame starting at a negedge with inputs already set.
  // b1: cycle (after tx_start) in which tx_busy is high, -1 for never.
  task automatic do_frame(input int b1, input bit spur, input bit drop);
    r_lat = -1; r_gid = -1; r_fd_at = -1; r_fd_cnt = 0;
    r_to_at = -1; r_to_cnt = 0; r_idle_at = -1; r_dat = 'x; r_rdy = 'x;
    for (int i = 1; i <= 20 && r_lat < 0; i++) begin
      @(negedge clk_t);
      if (bus.tx_start) begin
        r_lat = i; r_gid = int'(bus.grant_id); r_dat = bus.tx_data; r_rdy = bus.req_ready;
      end
    end
    if (r_lat < 0) return;
    if (drop) bus.req_valid = bus.req_valid & ~r_rdy;
    bus.tx_busy = spur;
    for (int t = 1; t <= TO + GAP + 40 && r_idle_at < 0; t++) begin
      @(negedge clk_t);
      if (bus.frame_done) begin r_fd_cnt++; if (r_fd_at < 0) r_fd_at = t; end
      if (bus.timeout_err) begin r_to_cnt++; if (r_to_at < 0) r_to_at = t; end
      if (!bus.active) r_idle_at = t;
      bus.tx_busy = (t == b1);
    end
    bus.tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = $urandom;
    bus.tx_busy   = 1'b1;
    repeat (3) @(negedge clk_t);
    total_cnt++;
    if ({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_id, bus.active,
         bus.frame_done, bus.timeout_err} !== '0)
      $display("FAIL reset_outputs got %h expected 0", {bus.req_ready, bus.tx_start,
               bus.tx_data, bus.grant_id, bus.active, bus.frame_done, bus.timeout_err});
    else pass_cnt++;
    srst = 1'b0; bus.req_valid = '0; bus.tx_busy = 1'b0;
    @(negedge clk_t);
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL reset_idle active got %b expected 0", bus.active);
    else pass_cnt++;
    last_m = N - 1;
  endtask

  task automatic test_fairness();
    int exp;
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = 8'h10 + 8'(i);
    bus.req_valid = '1;
    for (int f = 0; f < 5; f++) begin
      exp = pick(4'b1111);
      do_frame($urandom_range(1, 20), 1'b0, 1'b0);
      total_cnt++;
      if (r_gid !== exp || r_gid !== (f % N))
        $display("FAIL fair_grant frame %0d got %0d expected %0d", f, r_gid, exp);
      else pass_cnt++;
      total_cnt++;
      if (r_dat !== 8'h10 + 8'(exp) || r_lat !== 1)
        $display("FAIL fair_data frame %0d got %h lat %0d expected %h lat 1", f, r_dat, r_lat, 8'h10 + 8'(exp));
      else pass_cnt++;
      last_m = exp;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_wrap();
    bus.req_valid = 4'b1000;
    do_frame(4, 1'b0, 1'b1);
    last_m = 3;
    bus.req_valid = 4'b1001;
    do_frame(6, 1'b0, 1'b1);
    total_cnt++;
    if (r_gid !== pick(4'b1001) || r_gid !== 0) $display("FAIL wrap_first got %0d expected 0", r_gid);
    else pass_cnt++;
    last_m = 0;
    do_frame(6, 1'b0, 1'b1);
    total_cnt++;
    if (r_gid !== 3) $display("FAIL wrap_second got %0d expected 3", r_gid);
    else pass_cnt++;
    last_m = 3;
  endtask

  task automatic test_single();
    bus.req_data = $urandom;
    bus.req_data[8*2 +: 8] = 8'hA5;
    bus.req_valid = 4'b0100;
    do_frame(11, 1'b0, 1'b1);
    total_cnt++;
    if (r_lat !== 1 || r_rdy !== 4'b0100 || r_gid !== 2)
      $display("FAIL single_accept lat %0d ready %b grant %0d expected 1 0100 2", r_lat, r_rdy, r_gid);
    else pass_cnt++;
    total_cnt++;
    if (r_dat !== 8'hA5) $display("FAIL single_data got %h expected a5", r_dat);
    else pass_cnt++;
    total_cnt++;
    if (r_fd_at !== 12 || r_fd_cnt !== 1 || r_to_cnt !== 0)
      $display("FAIL single_done at %0d count %0d to %0d expected 12 1 0", r_fd_at, r_fd_cnt, r_to_cnt);
    else pass_cnt++;
    total_cnt++;
    if (r_idle_at !== 11 + GAP + 1) $display("FAIL single_idle at %0d expected %0d", r_idle_at, 11 + GAP + 1);
    else pass_cnt++;
    last_m = 2;
  endtask

  task automatic test_timeout();
    bus.req_data[7:0] = 8'h5A;
    bus.req_valid = 4'b0001;
    do_frame(-1, 1'b0, 1'b1);
    total_cnt++;
    if (r_to_at !== TO || r_to_cnt !== 1 || r_fd_cnt !== 0 || r_dat !== 8'h5A)
      $display("FAIL timeout_pulse at %0d count %0d done %0d data %h expected %0d 1 0 5a",
               r_to_at, r_to_cnt, r_fd_cnt, r_dat, TO);
    else pass_cnt++;
    total_cnt++;
    if (r_idle_at !== TO + GAP) $display("FAIL timeout_idle at %0d expected %0d", r_idle_at, TO + GAP);
    else pass_cnt++;
    last_m = 0;
    bus.req_valid = 4'b0010;
    do_frame(TO - 1, 1'b0, 1'b1);
    total_cnt++;
    if (r_lat !== 1 || r_gid !== 1) $display("FAIL timeout_next lat %0d grant %0d expected 1 1", r_lat, r_gid);
    else pass_cnt++;
    total_cnt++;
    if (r_fd_cnt !== 1 || r_to_cnt !== 0 || r_fd_at !== TO)
      $display("FAIL coincide done %0d to %0d at %0d expected 1 0 %0d", r_fd_cnt, r_to_cnt, r_fd_at, TO);
    else pass_cnt++;
    last_m = 1;
    bus.req_valid = 4'b0100;
    do_frame(TO, 1'b0, 1'b1);
    total_cnt++;
    if (r_fd_cnt !== 0 || r_to_at !== TO) $display("FAIL late_busy done %0d to_at %0d expected 0 %0d", r_fd_cnt, r_to_at, TO);
    else pass_cnt++;
    last_m = 2;
  endtask

  task automatic test_spurious();
    bus.req_valid = '0;
    bus.tx_busy = 1'b1;
    @(negedge clk_t);
    total_cnt++;
    if (bus.frame_done !== 1'b0 || bus.active !== 1'b0)
      $display("FAIL spur_idle done %b active %b expected 0 0", bus.frame_done, bus.active);
    else pass_cnt++;
    bus.req_data = $urandom;
    bus.req_valid = 4'b1000;
    do_frame(7, 1'b1, 1'b1);
    total_cnt++;
    if (r_lat !== 1 || r_fd_cnt !== 1 || r_fd_at !== 8 || r_idle_at !== 7 + GAP + 1)
      $display("FAIL spur_issue lat %0d done %0d at %0d idle %0d expected 1 1 8 %0d",
               r_lat, r_fd_cnt, r_fd_at, r_idle_at, 7 + GAP + 1);
    else pass_cnt++;
    last_m = 3;
  endtask

  task automatic test_reset_wait();
    logic [7:0] b;
    bit seen;
    b = 8'($urandom);
    bus.req_data[8*2 +: 8] = b;
    bus.req_valid = 4'b0100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_t);
      seen = bus.tx_start;
    end
    total_cnt++;
    if (!seen) $display("FAIL rstwait_start got 0 expected 1");
    else pass_cnt++;
    repeat (3) @(negedge clk_t);
    srst = 1'b1;
    @(negedge clk_t);
    total_cnt++;
    if ({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_id, bus.active,
         bus.frame_done, bus.timeout_err} !== '0)
      $display("FAIL rstwait_outputs got %h expected 0", {bus.req_ready, bus.tx_start,
               bus.tx_data, bus.grant_id, bus.active, bus.frame_done, bus.timeout_err});
    else pass_cnt++;
    srst = 1'b0;
    last_m = N - 1;
    do_frame(5, 1'b0, 1'b1);
    total_cnt++;
    if (r_lat !== 1 || r_gid !== pick(4'b0100) || r_dat !== b)
      $display("FAIL rstwait_regrant lat %0d grant %0d data %h expected 1 2 %h", r_lat, r_gid, r_dat, b);
    else pass_cnt++;
    last_m = 2;
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    logic [N-1:0] erdy;
    int exp, b;
    for (int it = 0; it < 20; it++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      bus.req_data = $urandom;
      bus.req_valid = m;
      exp = pick(m);
      erdy = N'(1) << exp;
      b = $urandom_range(1, TO - 2);
      do_frame(b, 1'b0, 1'b1);
      total_cnt++;
      if (r_gid !== exp || r_rdy !== erdy || r_dat !== bus.req_data[8*exp +: 8])
        $display("FAIL rand_grant it %0d got %0d/%b/%h expected %0d/%b/%h", it, r_gid, r_rdy, r_dat,
                 exp, erdy, bus.req_data[8*exp +: 8]);
      else pass_cnt++;
      total_cnt++;
      if (r_fd_at !== b + 1 || r_idle_at !== b + GAP + 1 || r_to_cnt !== 0)
        $display("FAIL rand_timing it %0d done %0d idle %0d to %0d expected %0d %0d 0", it, r_fd_at,
                 r_idle_at, r_to_cnt, b + 1, b + GAP + 1);
      else pass_cnt++;
      last_m = exp;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    test_reset();
    test_fairness();
    test_wrap();
    test_single();
    test_timeout();
    test_spurious();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units");
    $fatal(1);
  end
endmodule
